// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types for the bit-serial adder controller.
// Revision    : 1.0
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : 1-bit combinational full-adder cell (propagate/generate form).
// Revision    : 1.0
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;
    logic w_g;

    assign w_p  = a ^ b;
    assign w_g  = a & b;
    assign s    = w_p ^ cin;
    assign cout = w_g | (w_p & cin);

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial WIDTH-bit adder, LSB first, one full-adder cell
//               reused over WIDTH cycles with valid/ready on both sides.
// Revision    : 1.0
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] sha_q, shb_q, res_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_fa_s, w_fa_c, w_last;

    full_adder u_fa (
        .a    (sha_q[0]),
        .b    (shb_q[0]),
        .cin  (carry_q),
        .s    (w_fa_s),
        .cout (w_fa_c)
    );

    assign w_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= SA_IDLE;
        else       state_q <= state_d;
    end

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            SA_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SA_RUN;
            end
            SA_RUN: begin
                if (w_last) state_d = SA_DONE;
            end
            SA_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = SA_IDLE;
            end
            default: state_d = SA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                SA_IDLE: begin
                    if (in_valid) begin
                        sha_q   <= a;
                        shb_q   <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                SA_RUN: begin
                    sha_q   <= sha_q >> 1;
                    shb_q   <= shb_q >> 1;
                    res_q   <= {w_fa_s, res_q[WIDTH-1:1]};
                    carry_q <= w_fa_c;
                    if (w_last) begin
                        // Old carry is the carry into the MSB; XOR with carry out gives signed overflow.
                        sum_q  <= {w_fa_s, res_q[WIDTH-1:1]};
                        cout_q <= w_fa_c;
                        ovf_q  <= carry_q ^ w_fa_c;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH = 8).
// Revision    : 1.0
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] es;
        logic         eco;
        logic         eov;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es,
                                input logic eco, input logic eov);
        chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, eco});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eov});
    endtask

    initial begin
        int           lat;
        logic [W:0]   ref_full;
        logic [W-1:0] ra, rb;
        logic         rc, rov;
        int           stall;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].va, vecs[i].vb, vecs[i].vc);
            wait_done(lat);
            chk("latency", lat, W);
            check_result($sformatf("vec%0d", i), vecs[i].es, vecs[i].eco, vecs[i].eov);
            consume();
            chk("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
        end

        // Reset on the third RUN cycle discards the operation and clears outputs
        start_op(8'h11, 8'h22, 1'b0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("midrun_rst", 8'h00, 1'b0, 1'b0);
        start_op(8'h12, 8'h34, 1'b1);
        wait_done(lat);
        chk("post_rst_latency", lat, W);
        check_result("post_rst", 8'h47, 1'b0, 1'b0);
        consume();

        // Backpressure with in_valid held high during RUN and DONE
        start_op(8'h3C, 8'h5A, 1'b1);
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            chk("run_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("stall_latency", lat, W);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_result("stall", 8'h97, 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        consume();
        check_result("retain_after_idle", 8'h97, 1'b0, 1'b1);

        // Random back-to-back traffic with random consumer stalls
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            rov = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
            start_op(ra, rb, rc);
            wait_done(lat);
            chk("rand_latency", lat, W);
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk("rand_out_valid", {31'd0, out_valid}, 32'd1);
            check_result("rand", ref_full[W-1:0], ref_full[W], rov);
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
